// File: rtl/multi_buffer_pkg.sv
// Shared types for the generation-indexed multi-bank buffer.
package multi_buffer_pkg;

    typedef logic [3:0] addr_t;
    typedef logic [7:0] data_t;
    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        CLEAR
    } buf_state_t;

endpackage

// File: rtl/multi_buffer_bank_ram.sv
// One storage bank: a single write port and two independent registered read ports.
module bank_ram #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are never reset; only the read registers are.
    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/multi_buffer.sv
// N-bank generation buffer: logic reads/writes the rd/wr banks, render reads a latched
// display bank; swaps advance the generation and optionally zero-fill the new write bank.
module multi_buffer
    import multi_buffer_pkg::*;
#(
    parameter  int DATA_W        = $bits(data_t),
    parameter  int DEPTH         = 2 ** $bits(addr_t),
    parameter  int NUM_BANKS     = 3,
    parameter  bit CLEAR_ON_SWAP = 1'b1,
    localparam int ADDR_W        = $clog2(DEPTH),
    localparam int BANK_W        = $clog2(NUM_BANKS)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] logic_addr_r,
    output logic [DATA_W-1:0] logic_data_r,
    input  logic [ADDR_W-1:0] logic_addr_w,
    input  logic [DATA_W-1:0] logic_data_w,
    input  logic              logic_wr_en,
    input  logic [ADDR_W-1:0] render_addr_r,
    output logic [DATA_W-1:0] render_data_r,
    input  logic              render_frame_in,
    input  logic              swap_in,
    output logic              swap_ack_out,
    output logic              busy_out,
    output logic [BANK_W-1:0] rd_bank_out,
    output logic [BANK_W-1:0] wr_bank_out,
    output logic [BANK_W-1:0] disp_bank_out
);

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

    buf_state_t        state_q, state_d;
    logic [BANK_W-1:0] g_q, disp_q, disp, wr_ptr;
    logic [BANK_W-1:0] rd_sel_q, disp_sel_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              ack_q, stall, do_swap;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] rd_l [NUM_BANKS];
    logic [DATA_W-1:0] rd_r [NUM_BANKS];

    // With two banks there is nothing to protect, so display simply follows rd.
    assign disp   = (NUM_BANKS >= 3) ? disp_q : g_q;
    assign wr_ptr = bank_inc(g_q);
    assign stall  = (NUM_BANKS >= 3) && (bank_inc(wr_ptr) == disp_q);

    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_in) begin
                    if (stall) begin
                        state_d = PENDING;
                    end else begin
                        do_swap = 1'b1;
                        state_d = CLEAR_ON_SWAP ? CLEAR : IDLE;
                    end
                end
            end
            PENDING: begin
                if (!stall) begin
                    do_swap = 1'b1;
                    state_d = CLEAR_ON_SWAP ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            g_q        <= '0;
            disp_q     <= '0;
            ack_q      <= 1'b0;
            clr_addr_q <= '0;
            rd_sel_q   <= '0;
            disp_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= do_swap;
            clr_addr_q <= (state_q == CLEAR) ? clr_addr_q + 1'b1 : '0;
            rd_sel_q   <= g_q;
            disp_sel_q <= disp;
            if (do_swap) g_q <= bank_inc(g_q);
            if (render_frame_in) disp_q <= g_q;
        end
    end

    // During CLEAR the fill owns the write port and user writes are dropped.
    always_comb begin
        ram_we    = logic_wr_en;
        ram_waddr = logic_addr_w;
        ram_wdata = logic_data_w;
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ram (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .we      (ram_we && (wr_ptr == BANK_W'(b))),
            .waddr   (ram_waddr),
            .wdata   (ram_wdata),
            .raddr_a (logic_addr_r),
            .rdata_a (rd_l[b]),
            .raddr_b (render_addr_r),
            .rdata_b (rd_r[b])
        );
    end

    assign logic_data_r  = rd_l[rd_sel_q];
    assign render_data_r = rd_r[disp_sel_q];
    assign swap_ack_out  = ack_q;
    assign busy_out      = (state_q != IDLE);
    assign rd_bank_out   = g_q;
    assign wr_bank_out   = wr_ptr;
    assign disp_bank_out = disp;

endmodule

// File: tb/tb_multi_buffer.sv
// Directed bench: a 3-bank/16-deep/8-bit instance checked every cycle against a
// generation-level model, plus a 2-bank 1-bit legacy instance checked by hand.
module tb_multi_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 3-bank instance
    logic [3:0] la_r, la_w, ra_r;
    logic [7:0] ld_w, dl, dr;
    logic       lwe, frame, swap, ack, busy;
    logic [1:0] rd, wr, disp;

    // 2-bank legacy instance
    logic [3:0] la_r2, la_w2, ra_r2;
    logic       ld_w2, dl2, dr2, lwe2, frame2, swap2, ack2, busy2;
    logic       rd2, wr2, disp2;

    multi_buffer #(.DATA_W(8), .DEPTH(16), .NUM_BANKS(3), .CLEAR_ON_SWAP(1'b1)) dut (
        .clk_in(clk), .rst_in(rst),
        .logic_addr_r(la_r), .logic_data_r(dl),
        .logic_addr_w(la_w), .logic_data_w(ld_w), .logic_wr_en(lwe),
        .render_addr_r(ra_r), .render_data_r(dr), .render_frame_in(frame),
        .swap_in(swap), .swap_ack_out(ack), .busy_out(busy),
        .rd_bank_out(rd), .wr_bank_out(wr), .disp_bank_out(disp)
    );

    multi_buffer #(.DATA_W(1), .DEPTH(16), .NUM_BANKS(2), .CLEAR_ON_SWAP(1'b0)) dut2 (
        .clk_in(clk), .rst_in(rst),
        .logic_addr_r(la_r2), .logic_data_r(dl2),
        .logic_addr_w(la_w2), .logic_data_w(ld_w2), .logic_wr_en(lwe2),
        .render_addr_r(ra_r2), .render_data_r(dr2), .render_frame_in(frame2),
        .swap_in(swap2), .swap_ack_out(ack2), .busy_out(busy2),
        .rd_bank_out(rd2), .wr_bank_out(wr2), .disp_bank_out(disp2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Generation-level model of the 3-bank instance
    int       m_g, m_disp, m_clr;
    bit       m_pend, m_ack, m_live;
    bit [7:0] m_mem [3][16];
    bit       m_ok  [3][16];
    bit [7:0] e_l, e_r;
    bit       e_l_ok, e_r_ok;

    initial begin
        m_live = 0;
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < 16; a++) m_ok[b][a] = 0;
    end

    always @(posedge clk) begin : model
        int  g_old, d_old, wb;
        bit  was_busy;
        if (rst) begin
            m_g = 0; m_disp = 0; m_pend = 0; m_clr = 0; m_ack = 0;
            e_l = 0; e_r = 0; e_l_ok = 1; e_r_ok = 1;
        end else begin
            g_old = m_g; d_old = m_disp; wb = (g_old + 1) % 3;
            e_l = m_mem[g_old][la_r]; e_l_ok = m_ok[g_old][la_r];
            e_r = m_mem[d_old][ra_r]; e_r_ok = m_ok[d_old][ra_r];
            was_busy = m_pend || (m_clr > 0);
            if (m_clr > 0) begin
                m_mem[wb][16 - m_clr] = 0; m_ok[wb][16 - m_clr] = 1; m_clr--;
            end else if (lwe) begin
                m_mem[wb][la_w] = ld_w; m_ok[wb][la_w] = 1;
            end
            m_ack = 0;
            if (m_pend || (swap && !was_busy)) begin
                if ((g_old + 2) % 3 == d_old) m_pend = 1;
                else begin
                    m_pend = 0; m_g = (g_old + 1) % 3; m_ack = 1; m_clr = 16;
                end
            end
            if (frame) m_disp = g_old;
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_rd", rd, m_g);
            chk("m_wr", wr, (m_g + 1) % 3);
            chk("m_disp", disp, m_disp);
            chk("m_busy", busy, m_pend || (m_clr > 0));
            chk("m_ack", ack, m_ack);
            if (e_l_ok) chk("m_logic_data", dl, e_l);
            if (e_r_ok) chk("m_render_data", dr, e_r);
            chk("legacy_busy", busy2, 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && busy; i++) cyc();
        chk("idle_reached", busy, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nb;
        rst = 1; la_r = 0; la_w = 0; ra_r = 0; ld_w = 0; lwe = 0; frame = 0; swap = 0;
        la_r2 = 0; la_w2 = 0; ra_r2 = 0; ld_w2 = 0; lwe2 = 0; frame2 = 0; swap2 = 0;
        repeat (2) cyc();
        chk("rst_rd", rd, 0); chk("rst_wr", wr, 1); chk("rst_disp", disp, 0);
        chk("rst_busy", busy, 0); chk("rst_ack", ack, 0);
        chk("rst_ldata", dl, 0); chk("rst_rdata", dr, 0);
        rst = 0;

        // Prefill bank 2 with 0xFF while it is the write bank
        swap = 1; cyc(); swap = 0;
        wait_idle();
        for (int a = 0; a < 16; a++) begin
            lwe = 1; la_w = 4'(a); ld_w = 8'hFF; cyc();
        end
        lwe = 0;
        rst = 1; cyc(); rst = 0;

        // Basic swap and clear of the prefilled bank
        lwe = 1; la_w = 0; ld_w = 8'hA5; cyc(); lwe = 0;
        swap = 1; cyc(); swap = 0;
        chk("swap_ack", ack, 1); chk("swap_rd", rd, 1); chk("swap_wr", wr, 2);
        chk("swap_disp", disp, 0); chk("swap_busy", busy, 1);
        nb = 1;
        la_r = 0; ra_r = 0; lwe = 1; la_w = 0; ld_w = 8'h33; cyc(); lwe = 0;
        chk("ack_one_cycle", ack, 0); chk("swap_ldata", dl, 8'hA5);
        if (busy) nb++;
        for (int i = 0; i < 40 && busy; i++) begin
            cyc();
            if (busy) nb++;
        end
        chk("clear_len", nb, 16);
        chk("disp_before_frame", disp, 0);
        frame = 1; cyc(); frame = 0;
        chk("frame_disp", disp, 1);
        cyc();
        chk("frame_rdata", dr, 8'hA5);

        // Rotate the cleared bank into rd and read it back
        swap = 1; cyc(); swap = 0;
        chk("swap2_rd", rd, 2);
        for (int a = 0; a < 16; a++) begin
            la_r = 4'(a); cyc();
            chk("cleared_word", dl, 0);
        end
        wait_idle();

        // Stall against the displayed bank
        rst = 1; cyc(); rst = 0;
        swap = 1; cyc(); swap = 0;
        wait_idle();
        swap = 1; cyc(); swap = 0;
        chk("pend_busy", busy, 1); chk("pend_ack", ack, 0); chk("pend_rd", rd, 1);
        repeat (2) cyc();
        chk("pend_hold_busy", busy, 1); chk("pend_hold_ack", ack, 0);
        frame = 1; cyc(); frame = 0;
        chk("pend_old_disp_ack", ack, 0); chk("pend_frame_disp", disp, 1);
        cyc();
        chk("stall_ack", ack, 1); chk("stall_rd", rd, 2);
        chk("stall_wr", wr, 0); chk("stall_disp", disp, 1);

        // Swap while busy is ignored; reset on clear cycle 5 aborts
        swap = 1; cyc(); swap = 0;
        chk("busy_swap_ignored", rd, 2);
        repeat (3) cyc();
        chk("clear_cycle5_busy", busy, 1);
        rst = 1; cyc(); rst = 0;
        chk("abort_rd", rd, 0); chk("abort_wr", wr, 1); chk("abort_disp", disp, 0);
        chk("abort_busy", busy, 0); chk("abort_ack", ack, 0);
        repeat (2) cyc();
        chk("abort_stays_idle", busy, 0); chk("abort_no_queued", rd, 0);

        // Legacy two-bank behaviour
        lwe2 = 1; la_w2 = 0; ld_w2 = 1'b1; cyc(); lwe2 = 0;
        swap2 = 1; cyc(); swap2 = 0;
        chk("leg_ack", ack2, 1); chk("leg_rd", rd2, 1);
        chk("leg_wr", wr2, 0); chk("leg_disp", disp2, 1);
        cyc();
        chk("leg_ldata", dl2, 1); chk("leg_rdata", dr2, 1);
        frame2 = 1; cyc(); frame2 = 0;
        chk("leg_frame_ignored", disp2, 1);
        swap2 = 1; cyc(); swap2 = 0;
        chk("leg_wrap_rd", rd2, 0); chk("leg_wrap_disp", disp2, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
